// File: rtl/button_press_ctrl.sv
// Debounce and press classifier: turns a synchronized button level into clean
// press/release/long-press/repeat pulses, a held level and a wrapping press count.
module button_press_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sigSync,
    input  logic       rising_ind,
    output logic       press,
    output logic       release_p,
    output logic       long_press,
    output logic       repeat_p,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG_HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             timer_wrap;
    logic             long_flag;
    logic             long_flag_next;
    logic             press_next;
    logic             release_next;
    logic             long_next;
    logic             repeat_next;
    logic             held_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            long_flag   <= 1'b0;
            press       <= 1'b0;
            release_p   <= 1'b0;
            long_press  <= 1'b0;
            repeat_p    <= 1'b0;
            held        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            long_flag  <= long_flag_next;
            press      <= press_next;
            release_p  <= release_next;
            long_press <= long_next;
            repeat_p   <= repeat_next;
            held       <= held_next;
            if (press_next) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    // A low level always takes precedence over a timer expiry in the same cycle.
    always_comb begin
        state_next     = state;
        long_flag_next = long_flag;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;
        repeat_next    = 1'b0;
        timer_wrap     = 1'b0;
        case (state)
            IDLE: begin
                if (rising_ind) begin
                    state_next = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!sigSync) begin
                    state_next = IDLE;
                end else if (timer == DEB_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!sigSync) begin
                    state_next = DEB_RELEASE;
                end else if (timer == LONG_LAST) begin
                    state_next     = LONG_HELD;
                    long_flag_next = 1'b1;
                    long_next      = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!sigSync) begin
                    state_next = DEB_RELEASE;
                end else if (timer == REP_LAST) begin
                    repeat_next = 1'b1;
                    timer_wrap  = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (sigSync) begin
                    state_next = long_flag ? LONG_HELD : PRESSED;
                end else if (timer == DEB_LAST) begin
                    state_next     = IDLE;
                    long_flag_next = 1'b0;
                    release_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state change restarts the timer; only LONG_HELD wraps in place.
        timer_next = (state_next != state || timer_wrap) ? '0 : timer + CNT_W'(1);
        held_next  = (state_next == PRESSED) || (state_next == LONG_HELD) ||
                     (state_next == DEB_RELEASE);
    end

endmodule

// File: tb/tb_button_press_ctrl.sv
// Self-checking bench for button_press_ctrl: directed scenarios plus random
// button waveforms compared cycle by cycle against a behavioural model.
module tb_button_press_ctrl;

    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sig_sync = 1'b0;
    logic       rising_ind = 1'b0;
    logic       press;
    logic       release_p;
    logic       long_press;
    logic       repeat_p;
    logic       held;
    logic [7:0] press_count;

    button_press_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .REPEAT_CYCLES(R),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sigSync(sig_sync),
        .rising_ind(rising_ind),
        .press(press),
        .release_p(release_p),
        .long_press(long_press),
        .repeat_p(repeat_p),
        .held(held),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit prev_sig = 1'b0;

    // Model: "candidate" press under debounce, accepted press, release under debounce.
    bit       m_cand, m_acc, m_rel, m_long_seen;
    int       m_stable, m_age;
    bit [7:0] m_count;
    bit       m_press, m_release, m_long, m_repeat;

    function automatic logic [12:0] observed();
        return {press, release_p, long_press, repeat_p, held, press_count};
    endfunction

    function automatic logic [12:0] expected();
        return {m_press, m_release, m_long, m_repeat, m_acc, m_count};
    endfunction

    task automatic modelReset();
        m_cand = 0; m_acc = 0; m_rel = 0; m_long_seen = 0;
        m_stable = 0; m_age = 0; m_count = 8'd0;
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
    endtask

    task automatic modelStep(input bit sig, input bit rise);
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        if (!m_acc) begin
            if (!m_cand) begin
                if (rise) begin
                    m_cand = 1; m_stable = 0;
                end
            end else if (!sig) begin
                m_cand = 0;
            end else begin
                m_stable++;
                if (m_stable == D) begin
                    m_cand = 0; m_acc = 1; m_age = 0;
                    m_press = 1; m_count = m_count + 8'd1;
                end
            end
        end else if (m_rel) begin
            if (sig) begin
                m_rel = 0; m_age = 0;
            end else begin
                m_stable++;
                if (m_stable == D) begin
                    m_rel = 0; m_acc = 0; m_long_seen = 0; m_release = 1;
                end
            end
        end else if (!sig) begin
            m_rel = 1; m_stable = 0;
        end else begin
            m_age++;
            if (!m_long_seen && m_age == L) begin
                m_long_seen = 1; m_long = 1; m_age = 0;
            end else if (m_long_seen && m_age == R) begin
                m_repeat = 1; m_age = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sig);
        bit rise;
        rise = sig && !prev_sig;
        sig_sync = sig;
        rising_ind = rise;
        @(posedge clk);
        modelStep(sig, rise);
        prev_sig = sig;
        #1;
        checkOutput("cycle", observed(), expected());
    endtask

    task automatic doReset();
        reset = 1'b0;
        sig_sync = 1'b0;
        rising_ind = 1'b0;
        prev_sig = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", observed(), 13'd0);
        reset = 1'b1;
    endtask

    // Clean press held through long press and repeats, then a real or bouncing release.
    task automatic holdScenario(input bit bounce);
        doReset();
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b1);
            if (c == 4) begin
                checkOutput("press_c5", {12'd0, press}, 13'd1);
                checkOutput("count_c5", {5'd0, press_count}, 13'd1);
            end
            if (c == 14) checkOutput("long_c15", {12'd0, long_press}, 13'd1);
        end
        if (!bounce) begin
            for (int c = 30; c < 35; c++) applyStimulus(1'b0);
            checkOutput("release_c35", {11'd0, release_p, held}, 13'b10);
        end else begin
            applyStimulus(1'b0);
            applyStimulus(1'b0);
            for (int c = 32; c < 41; c++) begin
                applyStimulus(1'b1);
                if (c == 32) checkOutput("held_c33", {12'd0, held}, 13'd1);
            end
        end
    endtask

    initial begin
        $display("[TB] starting button_press_ctrl bench");
        modelReset();

        holdScenario(1'b0);
        holdScenario(1'b1);

        // Press bounce: gone before debounce completes.
        doReset();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("bounce", {3'd0, press, held, press_count}, 13'd0);
        repeat (3) applyStimulus(1'b0);

        // 256 complete press/release cycles wrap the counter back to zero.
        doReset();
        for (int n = 0; n < 256; n++) begin
            repeat (D + 2) applyStimulus(1'b1);
            repeat (D + 2) applyStimulus(1'b0);
        end
        checkOutput("wrap", {5'd0, press_count}, 13'd0);

        // Asynchronous reset in the middle of a long hold.
        doReset();
        repeat (20) applyStimulus(1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", observed(), 13'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) applyStimulus(1'b1);
        repeat (3) applyStimulus(1'b0);

        // Random button waveforms of varying run lengths.
        doReset();
        for (int s = 0; s < 300; s++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            repeat (len) applyStimulus(lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
